// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and helpers for the hit window counter.
// Holds the FSM state enum, default sizes and the saturating increment.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2
  } state_e;

  localparam int WIN_LEN_DEF = 16;
  localparam int CNT_W_DEF   = 5;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] cnt,
    input logic [31:0] max
  );
    return (cnt >= max) ? max : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/seq_hit_outreg.sv
// seq_hit_outreg: one-entry valid/ready result register with sticky overrun.
// Ports: load/data/sat in (opt. pos_in/vld_in), ready, ovr_clr; valid/data_o/sat_o/ovr out.
// Optional first-hit fields when SEQ_HIT_FIRSTPOS_EN is defined.
module seq_hit_outreg
  import seq_det_pkg::*;
#(
`ifdef SEQ_HIT_FIRSTPOS_EN
  parameter int PW    = 4,
`endif
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] data,
  input  logic             sat,
`ifdef SEQ_HIT_FIRSTPOS_EN
  input  logic [PW-1:0]    pos_in,
  input  logic             vld_in,
  output logic [PW-1:0]    pos_o,
  output logic             vld_o,
`endif
  input  logic             ready,
  input  logic             ovr_clr,
  output logic             valid,
  output logic [CNT_W-1:0] data_o,
  output logic             sat_o,
  output logic             ovr
);

  logic             valid_q, valid_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic             sat_q, sat_d;
  logic             ovr_q, ovr_d;
  logic             accept, drop;
`ifdef SEQ_HIT_FIRSTPOS_EN
  logic [PW-1:0]    pos_q, pos_d;
  logic             vld_q, vld_d;
`endif

  // Slot frees up in the same cycle the consumer takes the old result.
  assign accept = load && (!valid_q || ready);
  assign drop   = load && !accept;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sat_d   = sat_q;
    ovr_d   = ovr_q;
`ifdef SEQ_HIT_FIRSTPOS_EN
    pos_d   = pos_q;
    vld_d   = vld_q;
`endif
    if (accept) begin
      valid_d = 1'b1;
      data_d  = data;
      sat_d   = sat;
`ifdef SEQ_HIT_FIRSTPOS_EN
      pos_d   = pos_in;
      vld_d   = vld_in;
`endif
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    // A new drop beats a clear in the same cycle.
    if (drop) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SEQ_HIT_FIRSTPOS_EN
      pos_q   <= '0;
      vld_q   <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
      ovr_q   <= ovr_d;
`ifdef SEQ_HIT_FIRSTPOS_EN
      pos_q   <= pos_d;
      vld_q   <= vld_d;
`endif
    end
  end

  assign valid  = valid_q;
  assign data_o = data_q;
  assign sat_o  = sat_q;
  assign ovr    = ovr_q;
`ifdef SEQ_HIT_FIRSTPOS_EN
  assign pos_o  = pos_q;
  assign vld_o  = vld_q;
`endif

endmodule

// File: rtl/seq_hit_window_counter.sv
// seq_hit_window_counter: counts 1101-detector hits over WIN_LEN enabled bits.
// In: clk, rst(sync low), bit_en, hit, start, stop, ovr_clr, cnt_ready.
// Out: cnt_valid, cnt_data, cnt_sat, ovr, busy (+first_pos/first_vld
// when SEQ_HIT_FIRSTPOS_EN is defined).
module seq_hit_window_counter
  import seq_det_pkg::*;
#(
  parameter int WIN_LEN = WIN_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_en,
  input  logic                       hit,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       ovr_clr,
  input  logic                       cnt_ready,
  output logic                       cnt_valid,
  output logic [CNT_W-1:0]           cnt_data,
  output logic                       cnt_sat,
`ifdef SEQ_HIT_FIRSTPOS_EN
  output logic [$clog2(WIN_LEN)-1:0] first_pos,
  output logic                       first_vld,
`endif
  output logic                       ovr,
  output logic                       busy
);

  localparam int IW = $clog2(WIN_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIN_LEN - 1);
  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic             counting, hit_now, close, clip;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_nxt;

  assign counting = (state_q != S_IDLE) && bit_en;
  assign hit_now  = counting && hit;
  assign close    = counting && (idx_q == LAST_IDX);
  assign clip     = hit_now && (32'(cnt_q) == CNT_MAX);
  assign cnt_nxt  = hit_now ? CNT_W'(sat_inc(32'(cnt_q), CNT_MAX))
                            : cnt_q;
  // Includes the closing bit, so its hit lands in the closing window.
  assign sat_nxt  = sat_q | clip;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = stop ? S_LAST : S_RUN;
      S_RUN:  if (stop)  state_d = S_LAST;
      S_LAST: if (close) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (state_q == S_IDLE || close) begin
      idx_d = '0;
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (counting) begin
      idx_d = idx_q + IW'(1);
      cnt_d = cnt_nxt;
      sat_d = sat_nxt;
    end
  end

`ifdef SEQ_HIT_FIRSTPOS_EN
  logic [IW-1:0] fpos_q, fpos_d;
  logic          fvld_q, fvld_d;
  logic [IW-1:0] pub_pos;
  logic          pub_vld;

  assign pub_vld = fvld_q | hit_now;
  assign pub_pos = fvld_q  ? fpos_q :
                   hit_now ? idx_q  : '0;

  always_comb begin
    fpos_d = fpos_q;
    fvld_d = fvld_q;
    if (state_q == S_IDLE || close) begin
      fpos_d = '0;
      fvld_d = 1'b0;
    end else if (hit_now && !fvld_q) begin
      fpos_d = idx_q;
      fvld_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
`ifdef SEQ_HIT_FIRSTPOS_EN
      fpos_q  <= '0;
      fvld_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
`ifdef SEQ_HIT_FIRSTPOS_EN
      fpos_q  <= fpos_d;
      fvld_q  <= fvld_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);

  seq_hit_outreg #(
`ifdef SEQ_HIT_FIRSTPOS_EN
    .PW    (IW),
`endif
    .CNT_W (CNT_W)
  ) u_outreg (
    .clk     (clk),
    .rst     (rst),
    .load    (close),
    .data    (cnt_nxt),
    .sat     (sat_nxt),
`ifdef SEQ_HIT_FIRSTPOS_EN
    .pos_in  (pub_pos),
    .vld_in  (pub_vld),
    .pos_o   (first_pos),
    .vld_o   (first_vld),
`endif
    .ready   (cnt_ready),
    .ovr_clr (ovr_clr),
    .valid   (cnt_valid),
    .data_o  (cnt_data),
    .sat_o   (cnt_sat),
    .ovr     (ovr)
  );

endmodule
